step_seq: RTL
=============

# step_seq

Sequencer that drives the `step` systolic line through one complete GF(2) elimination pass over an L×K matrix held in `step`'s data memory. For each pivot column block it issues one `functionA=1` step, which computes and stores row operations. It then issues one `functionA=0` step for every later column block, which applies those operations. It sits directly upstream of `step`, owns `start`, `col_block` and `functionA`, and consumes `step`'s `done`.

## Interface
- `N`, 4: systolic line width; must match `step`.
- `L`, 8: matrix rows; must match `step`.
- `K`, 16: matrix columns; must match `step`. `NB = K/N` column blocks.
- `P`, L/N: number of pivot blocks processed; legal range 1..NB.
- `TIMEOUT`, 64: watchdog limit in cycles. Only present under `STEP_SEQ_TIMEOUT_EN`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  request a full pass; sampled only in IDLE or ERROR.
- `abort`  in  1  synchronous; returns the sequencer to IDLE on the next edge.
- `step_done`  in  1  `done` from `step`.
- `step_start`  out  1  one-cycle `start` pulse to `step`.
- `col_block`  out  $clog2(NB+1)  column block index to `step`.
- `functionA`  out  1  1 = pivot (compute ops); 0 = apply ops.
- `busy`  out  1  high from ISSUE of the first step until FINISH or abort.
- `finish`  out  1  one-cycle pulse when the pass completes.
- `step_count`  out  $clog2(P*NB+1)  number of steps completed in the current pass.
- `error`  out  1  watchdog tripped; sticky.

## Operation
- States: IDLE, ISSUE, WAIT, ADVANCE, FINISH, ERROR.
- Counters: pivot index `p` (0..P-1) and block index `c` (p..NB-1).
- IDLE, `go=1` (and `abort=0`): set p=0, c=0, step_count=0, go to ISSUE.
- ISSUE: assert `step_start` for exactly one cycle, then go to WAIT.
  - Outputs during ISSUE: `col_block=c`, `functionA=(c==p)`.
- WAIT:
  - Hold `col_block` and `functionA` stable until `step_done`.
  - `step` samples `functionA` continuously, so neither output may change mid-step.
  - On `step_done=1`: step_count+1, go to ADVANCE.
- ADVANCE:
  - If c<NB-1: c+1, go to ISSUE.
  - Else if p<P-1: p+1, c=p+1, go to ISSUE.
  - Else go to FINISH.
- FINISH: `finish=1` for one cycle, `busy=0`, go to IDLE.
- Step order for NB=4, P=2: (0,A) (1,B) (2,B) (3,B) (1,A) (2,B) (3,B). That is 7 steps; A = `functionA=1`, B = `functionA=0`.
- Total steps per pass: sum over p=0..P-1 of (NB−p).
- When p=NB−1 the pivot step is the only step for that p.
- `go` outside IDLE/ERROR: ignored.
- `step_done` outside WAIT: ignored; must not change any state.
- `abort=1` in any state: IDLE on the next edge.
  - `busy` and `step_start` deassert at that edge; `finish` is not pulsed.
  - Abort wins over a simultaneous `go` or `step_done`.
- The caller must not abort while `step` is mid-step unless it also resets `step`.
- Reset (any time, including mid-step): IDLE immediately.
  - All outputs go to 0: `step_start`, `col_block`, `functionA`, `busy`, `finish`, `step_count`, `error`.

## Timing
- All outputs are registered.
- `go` sampled at edge t: ISSUE state and `step_start=1` during cycle t+1, `busy=1` from t+1.
- `step_done` sampled at edge t: ADVANCE in cycle t+1, next `step_start` in cycle t+2. Overhead between steps is 2 cycles.
- Last `step_done` at edge t: `finish=1` in cycle t+2, `busy=0` from t+2.
- `step_count` updates on the edge after `step_done` is sampled. It holds its final value after FINISH until the next `go`.
- Back-to-back pass: `go` high during the FINISH cycle is ignored. `go` is accepted from the following IDLE cycle.

## Configuration
- `STEP_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter clears in ISSUE and counts each cycle in WAIT.
  - If it reaches `TIMEOUT` with no `step_done`, the next state is ERROR and `error=1`; `busy` stays 1.
  - ERROR holds `error=1` and keeps `col_block`/`functionA` frozen.
  - In ERROR, `go` restarts the pass (clears `error`); `abort` returns to IDLE and also clears `error`.
- `STEP_SEQ_TIMEOUT_EN` undefined:
  - No watchdog logic and no `TIMEOUT` parameter.
  - WAIT lasts indefinitely; `error` is tied to 0; the ERROR state is unreachable.

## Test plan
- Default params (NB=4, P=2): `go` pulse; bench model asserts `step_done` 20 cycles after each `step_start`.
  - Required: 7 starts in order (0,1)(1,0)(2,0)(3,0)(1,1)(2,0)(3,0) as (col_block, functionA).
  - Required: `finish` once, `step_count=7`, done→start gap of exactly 2 cycles.
- P=4, NB=4: 10 steps; the last step is (3,1) with no following B step; `finish` 2 cycles after its `step_done`.
- Spurious and ignored inputs:
  - `step_done` pulsed while in IDLE → no state change.
  - `go` pulsed mid-pass → no restart; `step_count` unaffected.
- `abort` in the same cycle as `step_done` during the 3rd step → IDLE next edge, `busy=0`, no `finish`, `step_count` stays 2.
- `rst` low for 1 cycle during WAIT → all outputs 0 immediately; a following `go` restarts from (0,1).
- `STEP_SEQ_TIMEOUT_EN` with TIMEOUT=64: `step_done` withheld → `error=1` after 64 WAIT cycles. A later `go` clears `error` and reissues (0,1).

Source files
------------

// File: rtl/step_seq.sv
// Purpose : sequences the step systolic line through one GF(2) elimination pass
//           (one pivot step per pivot block, then one apply step per later block).
// Latency : go -> first step_start 1 cycle; step_done -> next step_start 2 cycles;
//           last step_done -> finish 2 cycles.
// Backpressure: each step waits indefinitely for step_done; with STEP_SEQ_TIMEOUT_EN
//           defined, a watchdog of TIMEOUT WAIT cycles moves the pass to ERROR.
//
// Ports:
//   clk, rst (async active-low), go (start pass, sampled in IDLE/ERROR),
//   abort (sync return to IDLE), step_done (done from step),
//   step_start (1-cycle start to step), col_block / functionA (step operands),
//   busy, finish (1-cycle pass-complete pulse), step_count (completed steps),
//   error (sticky watchdog flag; constant 0 unless STEP_SEQ_TIMEOUT_EN).
module step_seq #(
    parameter int N = 4,
    parameter int L = 8,
    parameter int K = 16,
    parameter int P = L / N
`ifdef STEP_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic                          abort,
    input  logic                          step_done,
    output logic                          step_start,
    output logic [$clog2(K/N+1)-1:0]      col_block,
    output logic                          functionA,
    output logic                          busy,
    output logic                          finish,
    output logic [$clog2(P*(K/N)+1)-1:0]  step_count,
    output logic                          error
);

    localparam int NB  = K / N;
    localparam int CBW = $clog2(NB + 1);
    localparam int SCW = $clog2(P * NB + 1);

    localparam logic [CBW-1:0] NB_M1 = CBW'(NB - 1);
    localparam logic [CBW-1:0] P_M1  = CBW'(P - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    logic [2:0]     state, state_d;
    logic [CBW-1:0] p_q, p_d;
    logic [CBW-1:0] c_q, c_d;
    logic [SCW-1:0] cnt_d;

`ifdef STEP_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] wd_q;
    logic           wd_trip;

    // wd_q counts WAIT cycles already spent; the TIMEOUT-th WAIT cycle without
    // step_done trips the watchdog.
    assign wd_trip = (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else if (state == S_ISSUE) begin
            wd_q <= '0;
        end else if (state == S_WAIT && !wd_trip) begin
            wd_q <= wd_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state;
        p_d     = p_q;
        c_d     = c_q;
        cnt_d   = step_count;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    // ERROR is only reachable with the watchdog built in
                    if (go) begin
                        p_d     = '0;
                        c_d     = '0;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (step_done) begin
                        cnt_d   = step_count + 1'b1;
                        state_d = S_ADVANCE;
                    end
`ifdef STEP_SEQ_TIMEOUT_EN
                    else if (wd_trip) begin
                        state_d = S_ERROR;
                    end
`endif
                end
                S_ADVANCE: begin
                    if (c_q < NB_M1) begin
                        c_d     = c_q + 1'b1;
                        state_d = S_ISSUE;
                    end else if (p_q < P_M1) begin
                        // next pivot block starts on its own diagonal block
                        p_d     = p_q + 1'b1;
                        c_d     = p_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // All outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            p_q        <= '0;
            c_q        <= '0;
            step_count <= '0;
            step_start <= 1'b0;
            col_block  <= '0;
            functionA  <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            state      <= state_d;
            p_q        <= p_d;
            c_q        <= c_d;
            step_count <= cnt_d;
            step_start <= (state_d == S_ISSUE);
            finish     <= (state_d == S_FINISH);
            busy       <= (state_d == S_ISSUE) || (state_d == S_WAIT) ||
                          (state_d == S_ADVANCE) || (state_d == S_ERROR);
            // step samples functionA for the whole step, so the operands only
            // move when a new step is about to be issued.
            if (state_d == S_ISSUE) begin
                col_block <= c_d;
                functionA <= (c_d == p_d);
            end
        end
    end

`ifdef STEP_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error <= 1'b0;
        end else if (abort) begin
            error <= 1'b0;
        end else if (state == S_WAIT && !step_done && wd_trip) begin
            error <= 1'b1;
        end else if (state == S_ERROR && go) begin
            error <= 1'b0;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule
